// File: rtl/sram_req_ctrl.sv
// Valid/ready request front-end for sram_sp_sky130: single-cycle strobes, fixed-latency
// read tracking and a credit-guarded response FIFO. Optional bit-write mask: SRAM_REQ_CTRL_BWE_EN.
module sram_req_ctrl #(
    parameter int DATA_BIT  = 32,
    parameter int DEPTH     = 128,
    parameter int ADDR_BIT  = $clog2(DEPTH),
    parameter int READ_LAT  = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_BIT-1:0] req_addr,
    input  logic [DATA_BIT-1:0] req_wdata,
`ifdef SRAM_REQ_CTRL_BWE_EN
    input  logic [DATA_BIT-1:0] req_bwe,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_BIT-1:0] rsp_rdata,
    output logic                busy,
    output logic [ADDR_BIT-1:0] sram_addr,
    output logic                sram_wen,
    output logic                sram_ren,
    output logic [DATA_BIT-1:0] sram_wdata,
    output logic [DATA_BIT-1:0] sram_bwe,
    input  logic [DATA_BIT-1:0] sram_rdata
);

    localparam int PTR_BIT = $clog2(RSP_DEPTH);
    localparam int CNT_BIT = $clog2(RSP_DEPTH + 1);

    logic                acc;
    logic                rd_acc;
    logic                wr_acc;
    logic                push;
    logic                pop;
    logic [CNT_BIT-1:0]  credits_reg;
    logic [CNT_BIT-1:0]  credits_next;
    logic [CNT_BIT-1:0]  count_reg;
    logic [CNT_BIT-1:0]  count_next;
    logic [READ_LAT-1:0] pipe_reg;
    logic [READ_LAT-1:0] pipe_next;
    logic [PTR_BIT-1:0]  wr_ptr_reg;
    logic [PTR_BIT-1:0]  rd_ptr_reg;
    logic [PTR_BIT-1:0]  rd_ptr_next;
    logic [DATA_BIT-1:0] head_next;
    logic [DATA_BIT-1:0] fifo_mem [RSP_DEPTH];

    always_comb begin
        acc          = req_valid && req_ready;
        rd_acc       = acc && !req_we;
        wr_acc       = acc && req_we;
        pop          = rsp_valid && rsp_ready;
        push         = pipe_reg[READ_LAT-1];
        credits_next = credits_reg - CNT_BIT'(rd_acc) + CNT_BIT'(pop);
        count_next   = count_reg + CNT_BIT'(push) - CNT_BIT'(pop);
        pipe_next    = {pipe_reg[READ_LAT-2:0], rd_acc};
        rd_ptr_next  = rd_ptr_reg + PTR_BIT'(pop);
        // When the surviving queue is empty the new head is the word being pushed this edge.
        if (push && (count_reg == CNT_BIT'(pop))) begin
            head_next = sram_rdata;
        end else begin
            head_next = fifo_mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_reg <= CNT_BIT'(RSP_DEPTH);
            count_reg   <= '0;
            pipe_reg    <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            busy        <= 1'b0;
            sram_addr   <= '0;
            sram_wen    <= 1'b0;
            sram_ren    <= 1'b0;
            sram_wdata  <= '0;
            sram_bwe    <= '0;
        end else begin
            credits_reg <= credits_next;
            count_reg   <= count_next;
            pipe_reg    <= pipe_next;
            rd_ptr_reg  <= rd_ptr_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_BIT'(1);
            end
            req_ready <= (credits_next != '0);
            rsp_valid <= (count_next != '0);
            if (count_next != '0) begin
                rsp_rdata <= head_next;
            end
            busy     <= (pipe_next != '0) || (count_next != '0) || wr_acc;
            sram_wen <= wr_acc;
            sram_ren <= rd_acc;
            if (acc) begin
                sram_addr  <= req_addr;
                sram_wdata <= req_wdata;
            end
`ifdef SRAM_REQ_CTRL_BWE_EN
            if (wr_acc) begin
                sram_bwe <= req_bwe;
            end
`else
            sram_bwe <= '1;
`endif
        end
    end

    // Credits make these unreachable; they guard against integration mistakes.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_reg == CNT_BIT'(RSP_DEPTH))));
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(sram_wen && sram_ren));
    a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_valid && req_ready) || (int'(req_addr) < DEPTH));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl: directed vector table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_sram_req_ctrl;

    localparam int DATA_BIT  = 32;
    localparam int DEPTH     = 128;
    localparam int ADDR_BIT  = 7;
    localparam int READ_LAT  = 2;
    localparam int RSP_DEPTH = 4;
`ifdef SRAM_REQ_CTRL_BWE_EN
    localparam bit BWE_ON = 1'b1;
`else
    localparam bit BWE_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_we = 1'b0;
    logic [ADDR_BIT-1:0] req_addr = '0;
    logic [DATA_BIT-1:0] req_wdata = '0;
    logic [DATA_BIT-1:0] req_bwe = '1;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [DATA_BIT-1:0] rsp_rdata;
    logic                busy;
    logic [ADDR_BIT-1:0] sram_addr;
    logic                sram_wen;
    logic                sram_ren;
    logic [DATA_BIT-1:0] sram_wdata;
    logic [DATA_BIT-1:0] sram_bwe;
    logic [DATA_BIT-1:0] sram_rdata = '0;

    always #5 clk = ~clk;

    sram_req_ctrl #(
        .DATA_BIT(DATA_BIT), .DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT),
        .READ_LAT(READ_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SRAM_REQ_CTRL_BWE_EN
        .req_bwe(req_bwe),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy),
        .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_ren(sram_ren),
        .sram_wdata(sram_wdata), .sram_bwe(sram_bwe), .sram_rdata(sram_rdata)
    );

    // SRAM: commits writes on the negedge, registers read data on the sampling edge.
    logic [DATA_BIT-1:0] sram_mem [DEPTH];
    always @(negedge clk) begin
        if (sram_wen) sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_bwe) | (sram_wdata & sram_bwe);
    end
    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= sram_mem[sram_addr];
    end

    // Reference model: memory image plus an ordered queue of outstanding reads.
    typedef struct {
        logic [DATA_BIT-1:0] data;
        int                  rdy;
    } rsp_t;

    rsp_t                q[$];
    logic [DATA_BIT-1:0] ref_mem [DEPTH];
    bit                  ready_exp;
    int                  now;
    int                  checks;
    int                  errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit                  acc;
        bit                  rv_exp;
        bit                  exp_wen;
        bit                  exp_ren;
        logic [DATA_BIT-1:0] m;
        logic [ADDR_BIT-1:0] a;
        logic [DATA_BIT-1:0] wd;
        rv_exp = (q.size() > 0) && (q[0].rdy <= now);
        acc    = req_valid && ready_exp;
        a      = req_addr;
        wd     = req_wdata;
        if (rv_exp && rsp_ready) void'(q.pop_front());
        if (acc && req_we) begin
            m = BWE_ON ? req_bwe : '1;
            ref_mem[a] = (ref_mem[a] & ~m) | (wd & m);
        end
        if (acc && !req_we) q.push_back('{ref_mem[a], now + 1 + READ_LAT});
        exp_wen = acc && req_we;
        exp_ren = acc && !req_we;
        @(posedge clk);
        #1;
        now++;
        ready_exp = (q.size() < RSP_DEPTH);
        rv_exp    = (q.size() > 0) && (q[0].rdy <= now);
        chk("req_ready", 32'(req_ready), 32'(ready_exp));
        chk("rsp_valid", 32'(rsp_valid), 32'(rv_exp));
        chk("sram_wen", 32'(sram_wen), 32'(exp_wen));
        chk("sram_ren", 32'(sram_ren), 32'(exp_ren));
        chk("busy", 32'(busy), 32'((q.size() > 0) || exp_wen));
        if (acc) begin
            chk("sram_addr", 32'(sram_addr), 32'(a));
            chk("sram_wdata", sram_wdata, wd);
        end
        if (rv_exp) chk("rsp_rdata", rsp_rdata, q[0].data);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wen"}, 32'(sram_wen), 0);
        chk({tag, "_ren"}, 32'(sram_ren), 0);
        chk({tag, "_addr"}, 32'(sram_addr), 0);
        chk({tag, "_wdata"}, sram_wdata, 0);
        chk({tag, "_bwe"}, sram_bwe, 0);
        chk({tag, "_rdata"}, rsp_rdata, 0);
    endtask

    typedef struct {
        logic                valid;
        logic                we;
        logic [ADDR_BIT-1:0] addr;
        logic [DATA_BIT-1:0] wdata;
        logic [DATA_BIT-1:0] bwe;
        logic                exp_wen;
        logic                exp_ren;
        logic                exp_rv;
        logic [DATA_BIT-1:0] exp_rdata;
        logic                chk_bwe;
        logic [DATA_BIT-1:0] exp_bwe;
    } vec_t;

    vec_t vt[11];

    initial begin
        int dut_acc;
        int low_cnt;
        int rv_cnt;
        logic [DATA_BIT-1:0] held;
        checks    = 0;
        errors    = 0;
        now       = 0;
        ready_exp = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end

        vt[0]  = '{1, 1, 7'd5, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 1, 32'hFFFFFFFF};
        vt[1]  = '{1, 0, 7'd5, 32'h0,        32'h0,        0, 1, 0, 32'h0, 0, 32'h0};
        vt[2]  = '{0, 0, 7'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0, 0, 32'h0};
        vt[3]  = '{0, 0, 7'd0, 32'h0,        32'h0,        0, 0, 1, 32'hDEADBEEF, 0, 32'h0};
        vt[4]  = '{0, 0, 7'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0, 0, 32'h0};
        vt[5]  = '{1, 1, 7'd9, 32'h12345678, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 1, 32'hFFFFFFFF};
        vt[6]  = '{1, 1, 7'd9, 32'hFFFFFFFF, 32'h0000FFFF, 1, 0, 0, 32'h0, 1,
                   BWE_ON ? 32'h0000FFFF : 32'hFFFFFFFF};
        vt[7]  = '{1, 0, 7'd9, 32'h0,        32'h0,        0, 1, 0, 32'h0, 0, 32'h0};
        vt[8]  = '{0, 0, 7'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0, 0, 32'h0};
        vt[9]  = '{0, 0, 7'd0, 32'h0,        32'h0,        0, 0, 1,
                   BWE_ON ? 32'h1234FFFF : 32'hFFFFFFFF, 0, 32'h0};
        vt[10] = '{0, 0, 7'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0, 0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        idle(3);

        // Directed table: write/read-back latency and bit mask
        for (int i = 0; i < 11; i++) begin
            req_valid = vt[i].valid;
            req_we    = vt[i].we;
            req_addr  = vt[i].addr;
            req_wdata = vt[i].wdata;
            req_bwe   = vt[i].bwe;
            cycle();
            chk($sformatf("vec%0d_wen", i), 32'(sram_wen), 32'(vt[i].exp_wen));
            chk($sformatf("vec%0d_ren", i), 32'(sram_ren), 32'(vt[i].exp_ren));
            chk($sformatf("vec%0d_rv", i), 32'(rsp_valid), 32'(vt[i].exp_rv));
            if (vt[i].exp_rv) chk($sformatf("vec%0d_rdata", i), rsp_rdata, vt[i].exp_rdata);
            if (vt[i].chk_bwe) chk($sformatf("vec%0d_bwe", i), sram_bwe, vt[i].exp_bwe);
        end
        req_bwe = '1;

        // Back-to-back reads at full throughput
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 7'(i); req_wdata = 32'hA000_0000 + 32'(i);
            cycle();
        end
        low_cnt = 0;
        rv_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 7'(i);
            if (!req_ready) low_cnt++;
            cycle();
            if (rsp_valid) rv_cnt++;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (rsp_valid) rv_cnt++;
        end
        chk("b2b_ready_drops", 32'(low_cnt), 0);
        chk("b2b_rsp_cycles", 32'(rv_cnt), 8);

        // Back-pressure: only RSP_DEPTH reads get in
        rsp_ready = 1'b0;
        dut_acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 7'(i);
            if (req_ready) dut_acc++;
            cycle();
        end
        chk("bp_accepts", 32'(dut_acc), 4);
        idle(3);
        chk("bp_ready_low", 32'(req_ready), 0);
        held = rsp_rdata;
        idle(3);
        chk("bp_rdata_stable", rsp_rdata, held);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        chk("bp_ready_back", 32'(req_ready), 1);
        rsp_ready = 1'b1;
        idle(6);

        // FIFO near full with a read in flight, then pop every cycle while reading
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 7'(i + 3);
            cycle();
        end
        idle(1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 7'(i % 8);
            cycle();
        end
        idle(6);

        // Reset with reads in flight and FIFO occupied
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 7'(i);
            cycle();
        end
        req_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        q.delete();
        ready_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        idle(8);

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) != 0;
            req_addr  = 7'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_bwe   = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rsp_ready = 1'b1;
        idle(8);
        chk("drain_empty", 32'(rsp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
